// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Constants and types shared by the instruction-memory loader, its range
//   checker and the instruction cache.
//   IMEM_DEPTH   : instruction memory size in bytes
//   IMEM_BASE    : CPU byte address that maps to memory offset 0
//   IMEM_OFF_W   : width of a byte offset into the memory
//   WORD_W       : width of one instruction word
//   byte_off_t   : byte-offset type
//   load_state_t : loader FSM states
package imem_loader_pkg;

   localparam int          IMEM_DEPTH = 1024;
   localparam logic [31:0] IMEM_BASE  = 32'h8002_0000;
   localparam int          IMEM_OFF_W = $clog2(IMEM_DEPTH);
   localparam int          WORD_W     = 32;

   typedef logic [IMEM_OFF_W-1:0] byte_off_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_WAIT_WORD,
      ST_WRITE,
      ST_FINISH
   } load_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Word stream from a host or boot source into the loader.
//   in_valid : source presents a word on in_data
//   in_data  : 32-bit instruction word
//   in_ready : loader accepts in_data this cycle
//   Modports: master = word source, slave = loader.
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader_range_check.sv
// imem_range_check
//   Combinational alignment/bounds check for a block of words placed at a
//   CPU byte address. Usable by any path that writes a byte memory window.
//   addr_i   : CPU byte address of the first word
//   count_i  : number of 32-bit words
//   offset_o : byte offset of addr_i inside the memory window
//   err_o    : misaligned, start outside the window, or block overruns it
module imem_range_check
   import imem_loader_pkg::*;
#(
   parameter int          MEM_DEPTH = IMEM_DEPTH,
   parameter logic [31:0] BASE_ADDR = IMEM_BASE,
   parameter int          CNT_W     = 9
) (
   input  logic [31:0]                  addr_i,
   input  logic [CNT_W-1:0]             count_i,
   output logic [$clog2(MEM_DEPTH)-1:0] offset_o,
   output logic                         err_o
);

   logic [31:0] offset;
   logic [32:0] span_end;

   always_comb begin
      // Wrapping subtraction: addresses below the base become huge offsets
      // and fail the offset bound below.
      offset   = addr_i - BASE_ADDR;
      // One extra bit so offset + 4*count cannot wrap back into range.
      span_end = {1'b0, offset} + (33'(count_i) << 2);
      err_o    = (addr_i[1:0] != 2'b00)
              || (offset >= 32'(MEM_DEPTH))
              || (span_end > 33'(MEM_DEPTH));
      offset_o = offset[$clog2(MEM_DEPTH)-1:0];
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Loads a stream of 32-bit instruction words into the byte-wide
//   instruction memory, most-significant byte first, at consecutive
//   addresses, holding the CPU stalled while the load runs.
//   clock, reset_n         : clock, synchronous active-low reset
//   start                  : load request pulse (sampled only when idle)
//   start_addr, word_count : CPU byte address of first word, word count
//   src                    : word stream (slave side)
//   mem_we/addr/wdata      : byte write port to the instruction memory
//   busy                   : load in progress (CPU stall)
//   done                   : one-cycle completion pulse
//   error                  : sticky range/alignment error
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          MEM_DEPTH = IMEM_DEPTH,
   parameter logic [31:0] BASE_ADDR = IMEM_BASE,
   parameter int          CNT_W     = 9
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [31:0]                  start_addr,
   input  logic [CNT_W-1:0]             word_count,
   imem_loader_if.slave                 src,
   output logic                         mem_we,
   output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
   output logic [7:0]                   mem_wdata,
   output logic                         busy,
   output logic                         done,
   output logic                         error
);

   localparam int OFF_W = $clog2(MEM_DEPTH);

   load_state_t      state_q;
   logic [31:0]      addr_q;
   logic [CNT_W-1:0] remain_q;
   logic [OFF_W-1:0] off_q;
   logic [31:0]      word_q;
   logic [1:0]       byte_idx_q;
   logic             in_ready_q;
   logic             mem_we_q;
   logic [OFF_W-1:0] mem_addr_q;
   logic [7:0]       mem_wdata_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;

   logic [OFF_W-1:0] chk_offset;
   logic             chk_err;

   imem_range_check #(
      .MEM_DEPTH (MEM_DEPTH),
      .BASE_ADDR (BASE_ADDR),
      .CNT_W     (CNT_W)
   ) u_range (
      .addr_i   (addr_q),
      .count_i  (remain_q),
      .offset_o (chk_offset),
      .err_o    (chk_err)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remain_q    <= '0;
         off_q       <= '0;
         word_q      <= '0;
         byte_idx_q  <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q   <= start_addr;
                  remain_q <= word_count;
                  error_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               off_q <= chk_offset;
               if (chk_err) begin
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
               end else if (remain_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
               end else begin
                  in_ready_q <= 1'b1;
                  state_q    <= ST_WAIT_WORD;
               end
            end
            ST_WAIT_WORD: begin
               // Byte 0 goes out on the acceptance edge so the four bytes
               // occupy the four cycles right after the transfer.
               if (src.in_valid) begin
                  in_ready_q  <= 1'b0;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= off_q;
                  mem_wdata_q <= src.in_data[31:24];
                  word_q      <= {src.in_data[23:0], 8'h00};
                  byte_idx_q  <= 2'd1;
                  state_q     <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // byte_idx_q wraps to 0 once byte 3 is on the bus.
               if (byte_idx_q == 2'd0) begin
                  mem_we_q <= 1'b0;
                  off_q    <= off_q + OFF_W'(4);
                  remain_q <= remain_q - CNT_W'(1);
                  if (remain_q == CNT_W'(1)) begin
                     done_q  <= 1'b1;
                     state_q <= ST_FINISH;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= ST_WAIT_WORD;
                  end
               end else begin
                  mem_addr_q  <= off_q + OFF_W'(byte_idx_q);
                  mem_wdata_q <= word_q[31:24];
                  word_q      <= {word_q[23:0], 8'h00};
                  byte_idx_q  <= byte_idx_q + 2'd1;
               end
            end
            ST_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               in_ready_q <= 1'b0;
               mem_we_q   <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign src.in_ready = in_ready_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Drives directed and randomized loads into imem_loader and checks every
//   cycle against a transaction-level model of the load rules.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      start_addr = '0;
   logic [CNT_W-1:0] word_count = '0;
   logic             mem_we;
   byte_off_t        mem_addr;
   logic [7:0]       mem_wdata;
   logic             busy, done, error;

   imem_loader_if src_if ();

   imem_loader #(.MEM_DEPTH(IMEM_DEPTH), .BASE_ADDR(IMEM_BASE), .CNT_W(CNT_W)) dut (
      .clock      (clk),
      .reset_n    (reset_n),
      .start      (start),
      .start_addr (start_addr),
      .word_count (word_count),
      .src        (src_if),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          cyc = 0;
   bit          m_active = 0;
   bit          m_err = 0;
   bit          m_pend_err = 0;
   int          m_start = -100;
   int          m_done = -100;
   int          m_acc = -100;
   int          m_left = 0;
   logic [31:0] m_off = '0;
   logic [31:0] m_word = '0;
   logic [31:0] m_wbase = '0;
   int          took_cnt = 0;

   function automatic bit addr_bad(logic [31:0] a, int n);
      logic [31:0]     o;
      longint unsigned ol;
      o  = a - IMEM_BASE;
      ol = o;
      return (a[1:0] != 2'b00) || (ol >= 1024) || (ol + 4 * n > 1024);
   endfunction

   // Loader is ready whenever a load still owes words and the previous
   // word's four write cycles are over.
   function automatic bit exp_rdy(int c);
      return m_active && (m_left > 0) && (c > m_start) && (c - m_acc >= 4);
   endfunction

   always @(posedge clk) begin
      bit rdy_prev;
      rdy_prev = exp_rdy(cyc);
      cyc++;
      if (!reset_n) begin
         m_active = 0; m_err = 0; m_left = 0; m_acc = -100; m_done = -100;
      end else if (!m_active) begin
         if (start) begin
            m_active   = 1;
            m_start    = cyc;
            m_err      = 0;
            m_acc      = -100;
            m_off      = start_addr - IMEM_BASE;
            m_pend_err = addr_bad(start_addr, int'(word_count));
            if (m_pend_err || word_count == '0) begin
               m_left = 0;
               m_done = cyc + 1;
            end else begin
               m_left = int'(word_count);
               m_done = -100;
            end
         end
      end else begin
         if (cyc == m_done + 1) begin
            m_active = 0;
         end else begin
            if (cyc == m_start + 1 && m_pend_err) m_err = 1;
            if (rdy_prev && src_if.in_valid) begin
               m_acc   = cyc;
               m_word  = src_if.in_data;
               m_wbase = m_off;
               m_off   = m_off + 4;
               m_left--;
               took_cnt++;
               if (m_left == 0) m_done = cyc + 4;
            end
         end
      end
   end

   // ---------------- shadow instruction memory ----------------
   logic [7:0] shadow [0:IMEM_DEPTH-1];
   always @(posedge clk) if (mem_we === 1'b1) shadow[mem_addr] <= mem_wdata;

   function automatic logic [31:0] readback(logic [31:0] a);
      logic [31:0] o;
      int          i;
      o = a - IMEM_BASE;
      i = int'(o[IMEM_OFF_W-1:0]);
      return {shadow[i], shadow[i+1], shadow[i+2], shadow[i+3]};
   endfunction

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 0;
   int last_done = -1;
   int we_cnt = 0;

   always @(negedge clk) begin
      bit          exp_we;
      int          k;
      logic [31:0] ea;
      if (cmp_en) begin
         k      = cyc - m_acc;
         exp_we = m_active && (k >= 0) && (k <= 3);
         chk("in_ready", src_if.in_ready, exp_rdy(cyc));
         chk("mem_we", mem_we, exp_we);
         chk("busy", busy, m_active);
         chk("done", done, m_active && (cyc == m_done));
         chk("error", error, m_err);
         if (exp_we && mem_we === 1'b1) begin
            ea = m_wbase + k;
            chk("mem_addr", mem_addr, ea[IMEM_OFF_W-1:0]);
            chk("mem_wdata", mem_wdata, (m_word >> (24 - 8 * k)) & 32'hFF);
            $display("[TB] cyc %0d write off %0d byte %02h", cyc, mem_addr, mem_wdata);
         end
         if (done === 1'b1) last_done = cyc;
         if (mem_we === 1'b1) we_cnt++;
      end
   end

   // ---------------- word source ----------------
   logic [31:0] src_q [$];
   int src_mode = 0;  // 0: valid as soon as a word is queued, 1: fixed stall, 2: random stall
   int fixed_gap = 0;
   int flush_req = 0;
   int src_idx = 0, took_seen = 0, flush_seen = 0, stall = 0, cur_gap = 0;
   bit v = 0;

   always @(negedge clk) begin
      int g;
      if (flush_seen != flush_req) begin
         flush_seen = flush_req; src_idx = src_q.size(); took_seen = took_cnt; v = 0; stall = 0;
      end else if (took_seen != took_cnt) begin
         took_seen = took_cnt; src_idx++; v = 0; stall = 0; cur_gap = $urandom_range(0, 3);
      end
      g = (src_mode == 1) ? fixed_gap : cur_gap;
      if (!v && src_idx < src_q.size()) begin
         if (src_mode == 0) v = 1;
         else if (src_if.in_ready === 1'b1) begin
            if (stall >= g) v = 1;
            else stall++;
         end
      end
      src_if.in_valid = v;
      src_if.in_data  = (src_idx < src_q.size()) ? src_q[src_idx] : 32'hDEAD_BEEF;
   end

   // ---------------- sequencer ----------------
   int s_cyc = 0;

   task automatic do_start(logic [31:0] a, int n, bit dup);
      @(negedge clk);
      start = 1'b1; start_addr = a; word_count = CNT_W'(n);
      s_cyc = cyc + 1;
      @(negedge clk);
      if (dup) begin
         start_addr = IMEM_BASE; word_count = CNT_W'(3);
         @(negedge clk);
      end
      start = 1'b0;
      start_addr = $urandom();
   endtask

   task automatic wait_idle(int limit);
      int t;
      t = 0;
      while (m_active && t < limit) begin
         @(negedge clk);
         t++;
      end
      if (m_active) begin
         tests++; fails++;
         $display("FAIL load_timeout: still busy after %0d cycles", limit);
      end
      $display("[TB] load from %0d finished at cyc %0d error=%0b", s_cyc, cyc, error);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0, t;
      reset_n = 1'b0;
      start   = 1'b1;  // reset wins over a simultaneous start
      repeat (3) @(negedge clk);
      start = 1'b0;
      chk("rst_in_ready", src_if.in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      cmp_en  = 1;
      reset_n = 1'b1;
      @(negedge clk);

      // Two words, valid held high.
      src_mode = 0;
      src_q.push_back(32'h8FA4_0000); src_q.push_back(32'h27BD_FFF8);
      we0 = we_cnt;
      do_start(32'h8002_0000, 2, 0);
      wait_idle(100);
      chk("t1_done_lat", last_done - s_cyc, 11);
      chk("t1_writes", we_cnt - we0, 8);
      chk("t1_rb0", readback(32'h8002_0000), 32'h8FA4_0000);
      chk("t1_rb4", readback(32'h8002_0004), 32'h27BD_FFF8);

      // Source stalls 7 ready cycles before each word.
      src_mode = 1; fixed_gap = 7;
      src_q.push_back(32'h3C1D_8001); src_q.push_back(32'h0C00_0123);
      do_start(32'h8002_0000, 2, 0);
      wait_idle(200);
      chk("t2_done_lat", last_done - s_cyc, 25);
      chk("t2_rb0", readback(32'h8002_0000), 32'h3C1D_8001);
      chk("t2_rb4", readback(32'h8002_0004), 32'h0C00_0123);

      // Misaligned start.
      src_mode = 0;
      we0 = we_cnt;
      do_start(32'h8002_0002, 1, 0);
      wait_idle(50);
      chk("t3_done_lat", last_done - s_cyc, 1);
      chk("t3_writes", we_cnt - we0, 0);
      chk("t3_err_sticky", error, 1);

      // Overrun past the top of memory, then the largest legal load there.
      we0 = we_cnt;
      do_start(32'h8002_03FC, 2, 0);
      wait_idle(50);
      chk("t4_writes", we_cnt - we0, 0);
      chk("t4_err", error, 1);
      src_q.push_back(32'h1122_3344);
      we0 = we_cnt;
      do_start(32'h8002_03FC, 1, 0);
      wait_idle(100);
      chk("t4b_err", error, 0);
      chk("t4b_writes", we_cnt - we0, 4);
      chk("t4b_rb", readback(32'h8002_03FC), 32'h1122_3344);

      // Zero-word load.
      we0 = we_cnt;
      do_start(32'h8002_0010, 0, 0);
      wait_idle(50);
      chk("t5_done_lat", last_done - s_cyc, 1);
      chk("t5_writes", we_cnt - we0, 0);
      chk("t5_err", error, 0);

      // Reset during byte 2 of word 3 (offset 10).
      for (int i = 0; i < 4; i++) src_q.push_back(32'hA0B0_C000 + 32'(i));
      do_start(32'h8002_0000, 4, 0);
      t = 0;
      while (!(mem_we === 1'b1 && mem_addr == byte_off_t'(10)) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("t6_reached_byte", mem_addr, 10);
      reset_n = 1'b0;
      flush_req++;
      @(negedge clk);
      chk("t6_in_ready", src_if.in_ready, 0);
      chk("t6_mem_we", mem_we, 0);
      chk("t6_mem_addr", mem_addr, 0);
      chk("t6_mem_wdata", mem_wdata, 0);
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_error", error, 0);
      reset_n = 1'b1;
      src_q.push_back(32'h0000_0013); src_q.push_back(32'hDEAD_0001);
      do_start(32'h8002_0100, 2, 0);
      wait_idle(100);
      chk("t6b_err", error, 0);
      chk("t6b_rb0", readback(32'h8002_0100), 32'h0000_0013);
      chk("t6b_rb4", readback(32'h8002_0104), 32'hDEAD_0001);
      chk("t6_partial_kept", readback(32'h8002_0008) >> 8, 32'hA0B0C0);

      // Randomized loads with random source stalls and ignored restarts.
      src_mode = 2;
      for (int it = 0; it < 30; it++) begin
         int          r, n, offw;
         logic [31:0] a;
         r    = $urandom_range(0, 9);
         offw = $urandom_range(0, 255);
         n    = $urandom_range(0, 6);
         if (r < 6) begin
            a = IMEM_BASE + 32'(offw * 4);
            if (offw + n > 256) n = 256 - offw;
         end else if (r == 6) begin
            a = IMEM_BASE + 32'(offw * 4) + 32'($urandom_range(1, 3));
         end else if (r == 7) begin
            a = IMEM_BASE - 32'(4 * $urandom_range(1, 8));
         end else if (r == 8) begin
            a = IMEM_BASE + 32'(1024 + 4 * $urandom_range(0, 64));
         end else begin
            offw = $urandom_range(250, 255);
            a    = IMEM_BASE + 32'(offw * 4);
            n    = 256 - offw + $urandom_range(1, 4);
         end
         if (!addr_bad(a, n)) for (int w = 0; w < n; w++) src_q.push_back($urandom());
         do_start(a, n, $urandom_range(0, 2) == 0);
         wait_idle(400);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the instruction cache. Accepts a stream of 32-bit instruction words over a valid/ready handshake from a host or boot source.
- Writes each word into the byte-organised instruction memory, most-significant byte first (big-endian), at consecutive addresses.
- Holds the CPU stalled while loading and signals completion, so programs load at run time instead of only at simulation start.

Parameters:
- MEM_DEPTH, 1024, instruction memory size in bytes.
- BASE_ADDR, 32'h80020000, CPU address mapped to memory byte offset 0.
- CNT_W, 9, width of the word-count input.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse requesting a load; sampled only in IDLE.
- start_addr  in  32  CPU byte address of the first word.
- word_count  in  CNT_W  number of words to load.
- in_valid  in  1  source has a word on in_data.
- in_data  in  32  instruction word.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  $clog2(MEM_DEPTH)  byte offset written.
- mem_wdata  out  8  byte written.
- busy  out  1  load in progress; drives CPU stall.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky range/alignment error; cleared by next accepted start.

Behaviour:
- Reset (reset_n low at a rising edge): state IDLE. All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, error. Clears the word counter and byte counter.
- States: IDLE, CHECK, WAIT_WORD, WRITE, FINISH.
- IDLE -> CHECK on start. Latches start_addr and word_count, clears error, sets busy.
- CHECK (1 cycle) computes offset = start_addr - BASE_ADDR (32-bit, wrapping).
  - Error when start_addr[1:0] != 0, or offset >= MEM_DEPTH, or offset + 4*word_count > MEM_DEPTH. Compute the sum at 33+ bits so it cannot overflow.
  - On error: error=1, go to FINISH, no writes.
  - word_count == 0 with no error: go to FINISH, no writes.
  - Otherwise go to WAIT_WORD.
- WAIT_WORD: in_ready=1. A transfer occurs when in_valid && in_ready. The word is latched and the state moves to WRITE with byte index 0. With no in_valid the loader waits indefinitely.
- WRITE: 4 consecutive cycles with mem_we=1.
  - Byte k (k=0..3) drives mem_addr = offset+k and mem_wdata = word[31-8k -: 8].
  - After byte 3, offset += 4 and remaining -= 1. If remaining is now 0, go to FINISH; else go to WAIT_WORD.
  - in_ready=0 throughout WRITE.
- Latency and throughput:
  - Word accepted at edge N; its bytes are written at edges N+1..N+4; in_ready is high again in the cycle after N+4.
  - Peak rate is 1 word per 5 cycles.
- FINISH (1 cycle): done=1, busy=0 from the next cycle, return to IDLE. busy is high from the cycle after start through FINISH inclusive.
- start while not IDLE is ignored. in_valid outside WAIT_WORD is ignored; the source must hold data until ready.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Reset mid-load:
  - Returns to IDLE at that edge and mem_we drops.
  - Bytes already written stay in memory; a partially written word is allowed.
  - No done pulse, and error is cleared.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared package holds:
  - MEM_DEPTH and BASE_ADDR constants, shared with the icache.
  - The state enum typedef.
  - A byte-offset typedef of width $clog2(MEM_DEPTH).
- One natural sub-module: imem_range_check, a combinational alignment/bounds checker used in CHECK. It can be reused by the data-memory path.

Test Plan:
- Load 2 words to 0x80020000 (0x8FA40000, 0x27BDFFF8) with in_valid always high.
  - Bytes 8F,A4,00,00 land at offsets 0..3 on consecutive cycles, then 27,BD,FF,F8 at offsets 4..7.
  - done pulses exactly 1 cycle after the last write; busy covers the whole load.
  - Icache readback at 0x80020004 returns 0x27BDFFF8.
- Source stalls 7 cycles between words: in_ready stays high with no writes; resumes correctly at offset 4.
- start_addr 0x80020002, count 1: error=1, done pulses, zero mem_we cycles.
- start_addr 0x800203FC, count 2 (overruns 1024 bytes): error=1, no writes. Same address with count 1 loads successfully to offsets 1020..1023.
- word_count 0: done pulses 2 cycles after start; no in_ready, no writes.
- reset_n low during byte 2 of word 3: next cycle all outputs 0 and state IDLE. A fresh start then loads normally with error=0.
